// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder.
// Accepts a message as a byte stream and produces padded 512-bit blocks:
// message bytes, a 0x80 marker, zero fill, and the 64-bit message bit length.
// Blocks are offered on a valid/ready handshake, and the final block of each
// message is flagged.
module sha256_msg_padder (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] block,
    output logic         block_valid,
    output logic         block_last,
    input  logic         block_ready
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        LEN  = 2'd2,
        EMIT = 2'd3
    } state_t;

    state_t       state_reg;
    logic [7:0]   buf_reg [0:63];
    logic [5:0]   pos_reg;
    logic [60:0]  bytecnt_reg;
    logic         pad_pend_reg;
    logic         len_pend_reg;
    logic         last_flag_reg;
    logic         block_valid_reg;
    logic [63:0]  len_bits;

    // Bit length of the message so far, mod 2^64.
    assign len_bits = {bytecnt_reg, 3'b000};

    // Bytes are only taken while filling; held low throughout reset.
    assign in_ready    = (state_reg == FILL) && !reset;
    assign block_valid = block_valid_reg;
    // last_flag does not change while a block is offered, so it can drive
    // block_last directly.
    assign block_last  = last_flag_reg;

    // Byte 0 of the buffer is the most significant byte of the block.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_block_bytes
            assign block[511 - 8*gi -: 8] = buf_reg[gi];
        end
    endgenerate

    // Padding sequencer: fill, append the marker and length, then hand out the block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= FILL;
            pos_reg         <= 6'd0;
            bytecnt_reg     <= 61'd0;
            pad_pend_reg    <= 1'b0;
            len_pend_reg    <= 1'b0;
            last_flag_reg   <= 1'b0;
            block_valid_reg <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                buf_reg[i] <= 8'h00;
            end
        end else begin
            case (state_reg)
                FILL: begin
                    if (in_valid) begin
                        buf_reg[pos_reg] <= in_data;
                        pos_reg          <= pos_reg + 6'd1;
                        bytecnt_reg      <= bytecnt_reg + 61'd1;
                        if (pos_reg == 6'd63) begin
                            // Full block; a final byte here means the
                            // marker and length need a block of their own.
                            state_reg       <= EMIT;
                            block_valid_reg <= 1'b1;
                            last_flag_reg   <= 1'b0;
                            pad_pend_reg    <= in_last;
                        end else if (in_last) begin
                            state_reg <= PAD;
                        end
                    end
                end

                PAD: begin
                    buf_reg[pos_reg] <= 8'h80;
                    if (pos_reg <= 6'd55) begin
                        // Length field fits behind the marker.
                        for (int k = 56; k < 64; k++) begin
                            buf_reg[k] <= len_bits[8*(63-k) +: 8];
                        end
                        last_flag_reg <= 1'b1;
                    end else begin
                        // No room for the length; it goes into an extra block.
                        last_flag_reg <= 1'b0;
                        len_pend_reg  <= 1'b1;
                    end
                    state_reg       <= EMIT;
                    block_valid_reg <= 1'b1;
                end

                LEN: begin
                    for (int k = 56; k < 64; k++) begin
                        buf_reg[k] <= len_bits[8*(63-k) +: 8];
                    end
                    last_flag_reg   <= 1'b1;
                    len_pend_reg    <= 1'b0;
                    state_reg       <= EMIT;
                    block_valid_reg <= 1'b1;
                end

                EMIT: begin
                    if (block_ready) begin
                        // The clear provides all zero fill of later blocks.
                        for (int i = 0; i < 64; i++) begin
                            buf_reg[i] <= 8'h00;
                        end
                        pos_reg         <= 6'd0;
                        block_valid_reg <= 1'b0;
                        if (pad_pend_reg) begin
                            state_reg    <= PAD;
                            pad_pend_reg <= 1'b0;
                        end else if (len_pend_reg) begin
                            state_reg <= LEN;
                        end else begin
                            state_reg <= FILL;
                        end
                        if (last_flag_reg) begin
                            bytecnt_reg   <= 61'd0;
                            last_flag_reg <= 1'b0;
                        end
                    end
                end

                default: state_reg <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed testbench for sha256_msg_padder. Inputs change and outputs are
// sampled on the falling clock edge; expected blocks are hand-computed constants.
module tb_sha256_msg_padder;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic [511:0] block;
    logic         block_valid;
    logic         block_last;
    logic         block_ready;

    int total;
    int bad;

    sha256_msg_padder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .block       (block),
        .block_valid (block_valid),
        .block_last  (block_last),
        .block_ready (block_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", {511'd0, in_ready}, 512'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        $display("tx byte %h last=%0b", b, last);
    endtask

    // Waits for a block, holds block_ready low for 'hold' cycles while checking
    // stability, then takes it.
    task automatic get_block(input int hold, output logic [511:0] b, output logic l);
        int guard;
        guard = 0;
        while (!block_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("block_valid_wait", {511'd0, block_valid}, 512'd1);
        check("in_ready_in_emit", {511'd0, in_ready}, 512'd0);
        b = block;
        l = block_last;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_block", block, b);
            check("hold_last", {511'd0, block_last}, {511'd0, l});
            check("hold_valid", {511'd0, block_valid}, 512'd1);
            check("hold_in_ready", {511'd0, in_ready}, 512'd0);
        end
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
        check("valid_after_xfer", {511'd0, block_valid}, 512'd0);
        $display("rx block last=%0b data=%h", l, b);
    endtask

    task automatic send_abc();
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
    endtask

    logic [511:0] exp_abc;
    logic [511:0] exp_blk;
    logic [511:0] got;
    logic         got_last;
    logic [447:0] aa_fill;
    logic [511:0] fives;

    initial begin
        total       = 0;
        bad         = 0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        in_last     = 1'b0;
        block_ready = 1'b0;
        reset       = 1'b1;

        exp_abc          = '0;
        exp_abc[511:480] = 32'h61626380;
        exp_abc[31:0]    = 32'h00000018;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_block", block, 512'd0);
        check("rst_valid", {511'd0, block_valid}, 512'd0);
        check("rst_last", {511'd0, block_last}, 512'd0);
        check("rst_in_ready", {511'd0, in_ready}, 512'd0);
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", {511'd0, in_ready}, 512'd1);

        // "abc": valid two cycles after the last byte
        send_abc();
        check("abc_pad_cycle_valid", {511'd0, block_valid}, 512'd0);
        check("abc_pad_cycle_in_ready", {511'd0, in_ready}, 512'd0);
        @(negedge clk);
        check("abc_valid_at_t2", {511'd0, block_valid}, 512'd1);
        get_block(0, got, got_last);
        check("abc_block", got, exp_abc);
        check("abc_last", {511'd0, got_last}, 512'd1);

        // 56 bytes of 0xAA: marker in block 1, length in block 2
        for (int i = 0; i < 56; i++) send_byte(8'hAA, (i == 55));
        aa_fill = {56{8'hAA}};
        exp_blk          = '0;
        exp_blk[511:64]  = aa_fill;
        exp_blk[63:56]   = 8'h80;
        get_block(0, got, got_last);
        check("b56_blk1", got, exp_blk);
        check("b56_blk1_last", {511'd0, got_last}, 512'd0);
        exp_blk       = '0;
        exp_blk[63:0] = 64'h00000000000001C0;
        get_block(0, got, got_last);
        check("b56_blk2", got, exp_blk);
        check("b56_blk2_last", {511'd0, got_last}, 512'd1);

        // 64 bytes of 0x55: full block then a pad-only block
        for (int i = 0; i < 64; i++) send_byte(8'h55, (i == 63));
        fives = {64{8'h55}};
        get_block(0, got, got_last);
        check("b64_blk1", got, fives);
        check("b64_blk1_last", {511'd0, got_last}, 512'd0);
        exp_blk          = '0;
        exp_blk[511:504] = 8'h80;
        exp_blk[63:0]    = 64'h0000000000000200;
        get_block(0, got, got_last);
        check("b64_blk2", got, exp_blk);
        check("b64_blk2_last", {511'd0, got_last}, 512'd1);

        // Backpressure for 5 cycles, then repeat to confirm the count cleared
        send_abc();
        get_block(5, got, got_last);
        check("bp_block", got, exp_abc);
        check("bp_last", {511'd0, got_last}, 512'd1);
        send_abc();
        get_block(0, got, got_last);
        check("bp_repeat_block", got, exp_abc);
        check("bp_repeat_last", {511'd0, got_last}, 512'd1);

        // Gaps between input bytes
        send_byte(8'h61, 1'b0);
        @(negedge clk);
        send_byte(8'h62, 1'b0);
        @(negedge clk);
        send_byte(8'h63, 1'b1);
        get_block(0, got, got_last);
        check("gap_block", got, exp_abc);
        check("gap_last", {511'd0, got_last}, 512'd1);

        // Reset partway through a message
        for (int i = 0; i < 30; i++) send_byte(8'(i + 1), 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_valid", {511'd0, block_valid}, 512'd0);
        check("midrst_in_ready", {511'd0, in_ready}, 512'd0);
        check("midrst_block", block, 512'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_valid_after", {511'd0, block_valid}, 512'd0);
        send_abc();
        get_block(0, got, got_last);
        check("midrst_abc_block", got, exp_abc);
        check("midrst_abc_last", {511'd0, got_last}, 512'd1);
        @(negedge clk);
        check("midrst_no_extra_block", {511'd0, block_valid}, 512'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Upstream stage of the SHA-256 hashing path. It accepts a message as a byte stream and emits FIPS 180-4 §5.1.1 padded 512-bit blocks, one at a time, over a valid/ready handshake. Each block flags whether it is the final block of the message. The top-level sequencer consumes the blocks and drives the core's block/message load strobes.

## Interface
Parameters:
- None. Widths are fixed by SHA-256: 8-bit input, 512-bit block, 64-bit length field.

Ports:
- clk  in  1  Single clock; all state changes on posedge clk.
- reset  in  1  Asynchronous, active-high reset.
- in_valid  in  1  Byte on in_data is valid.
- in_data  in  8  Message byte, in stream order.
- in_last  in  1  Qualified by in_valid; marks the final byte of the message.
- in_ready  out  1  Padder accepts a byte this cycle. A byte transfers when in_valid & in_ready.
- block  out  512  Padded block. Stream byte i of the block sits at block[511-8i -: 8], i.e. big-endian, so word 0 is block[511:480].
- block_valid  out  1  block is complete and stable.
- block_last  out  1  Qualified by block_valid; this is the final block of the message.
- block_ready  in  1  Consumer takes the block. A block transfers when block_valid & block_ready.

## Operation
Internal state:
- 512-bit buffer.
- pos[5:0]: next byte slot in the buffer.
- bytecnt[60:0]: message length in bytes. Length field L = {bytecnt,3'b000}, taken mod 2^64.
- Flags pad_pend, len_pend, last_flag.

FSM states are FILL, PAD, LEN and EMIT.
- **FILL**
  - in_ready = 1.
  - On each transfer: buffer[pos] <= in_data; pos++; bytecnt++.
  - Transfer with pos==63:
    - Go to EMIT with last_flag=0.
    - If in_last is also set, set pad_pend=1.
  - Transfer with in_last and pos<63: go to PAD.
- **PAD** (one cycle, in_ready = 0)
  - buffer[pos] <= 0x80.
  - If pos<=55: write L into bytes 56..63 in the same cycle and go to EMIT with last_flag=1.
  - If pos>=56: go to EMIT with last_flag=0 and len_pend=1.
- **LEN** (one cycle, in_ready = 0)
  - Write L into bytes 56..63 of the zeroed buffer.
  - Go to EMIT with last_flag=1 and clear len_pend.
- **EMIT**
  - block_valid = 1; block_last = last_flag; in_ready = 0.
  - Hold until block_ready. On the transfer, clear the buffer to zero and set pos=0. Zero fill between 0x80 and the length field comes only from this clear.
  - Next state after the transfer:
    - PAD if pad_pend (then clear pad_pend).
    - Otherwise LEN if len_pend.
    - Otherwise FILL.
  - If last_flag was set, also clear bytecnt to 0 and last_flag to 0.

Rules and boundaries:
- block and block_last are held constant while block_valid is high and block_ready is low.
- block_ready is ignored while block_valid is low.
- in_valid is ignored while in_ready is low. There is no input buffering and no byte is lost.
- Zero-length messages are unsupported, because every message ends on a byte carrying in_last.
- Message of exactly 64k bytes: the pad block holds 0x80 at byte 0 and L at bytes 56..63.
- Final partial block of 56..63 bytes: two blocks are emitted.
- bytecnt wraps mod 2^61 without error.
- Reset mid-message or mid-EMIT discards all state immediately. No partial block is emitted.

## Timing
- Reset values:
  - State FILL; pos, bytecnt, buffer and all flags are 0.
  - block = 0, block_valid = 0, block_last = 0.
  - in_ready = 0 while reset is asserted, then 1 from the first cycle after deassertion.
- Full non-final block: last byte accepted at edge t, block_valid high from t+1.
- Final byte with pos<=55 accepted at edge t: PAD at t+1, block_valid from t+2.
- Extra length block: block_valid asserts one cycle (LEN) after the preceding block's transfer.
- Aligned message (pad_pend): the pad block's block_valid asserts one cycle (PAD) after the full-block transfer.
- FILL is re-entered the cycle after the final block's transfer. in_ready rises then, so the next message's first byte is accepted at the earliest one cycle after that transfer.
- Throughput: 1 byte/cycle in FILL. Each block costs at least 1 EMIT cycle.

## Test plan
- "abc" (0x61,0x62,0x63, in_last on 0x63), block_ready=1 → a single block with block_last=1:
  - word0 = 0x61626380, words 1..14 = 0, word15 = 0x00000018.
  - block_valid arrives 2 cycles after the last byte.
- 56-byte message of 0xAA → two blocks:
  - Block 1: bytes 0..55 = 0xAA, byte56 = 0x80, rest 0, block_last=0.
  - Block 2: all zero except bytes 56..63 = 0x00000000000001C0, block_last=1.
- 64-byte message of 0x55 → two blocks:
  - Block 1: all 0x55, last=0.
  - Block 2: byte0 = 0x80, L = 0x200, last=1.
- Backpressure: "abc" with block_ready held low for 5 cycles → block and block_last stable for all 5 cycles, in_ready=0 throughout, transfer on cycle 6. Then send "abc" again → identical block with L=0x18, proving bytecnt was cleared.
- Input gaps: "abc" sent with in_valid toggling 1,0,1,0,1 → the same block as the first scenario.
- Reset mid-stream: assert reset after 30 bytes of a message, then send "abc" → only the "abc" block is emitted, with L=0x18. block_valid is 0 during reset.
